register_file_32x32: RTL

//  - RISC-V integer register file: 32 x WIDTH architectural registers x0..x31.
//  - Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
//  - Downstream consumer of the 1-to-32 write-enable demux: the decoded one-hot enable gates each register's load.
//  - Sits between the writeback stage (writes) and decode/execute (operand reads).

---
 rtl/register_file_32x32_pkg.sv | 23 ++
 rtl/register_file_32x32_if.sv | 26 ++
 rtl/register_file_32x32_demux.sv | 17 +
 rtl/register_file_32x32.sv | 66 ++++++
 4 files changed

// File: rtl/register_file_32x32_pkg.sv
// Shared RISC-V constants and helpers for the integer register file slice.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   reg_onehot_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd1;
  localparam reg_addr_t REG_SP   = 5'd2;

  // An unknown index leaves the vector all-zero rather than spreading X.
  function automatic reg_onehot_t onehot_decode(input reg_addr_t sel);
    reg_onehot_t result;
    result      = '0;
    result[sel] = 1'b1;
    return result;
  endfunction

endpackage

// File: rtl/register_file_32x32_if.sv
// Writeback/operand-read bus between the pipeline and the register file.
interface register_file_32x32_if
  import rv_pkg::*;
#(
  parameter int WIDTH = XLEN
) ();

  logic             we;
  reg_addr_t        rd_addr;
  logic [WIDTH-1:0] rd_data;
  reg_addr_t        rs1_addr;
  logic [WIDTH-1:0] rs1_data;
  reg_addr_t        rs2_addr;
  logic [WIDTH-1:0] rs2_data;

  modport master (
    output we, rd_addr, rd_data, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data
  );

  modport slave (
    input  we, rd_addr, rd_data, rs1_addr, rs2_addr,
    output rs1_data, rs2_data
  );

endinterface

// File: rtl/register_file_32x32_demux.sv
// 1-to-32 single-bit demultiplexer: routes 'in' onto the output line picked by 'sel'.
module demultiplexor1bit_1_32
  import rv_pkg::*;
(
  input  logic        in,
  input  reg_addr_t   sel,
  output reg_onehot_t out
);

  always_comb begin
    out = '0;
    if (in) begin
      out = onehot_decode(sel);
    end
  end

endmodule

// File: rtl/register_file_32x32.sv
// RISC-V integer register file: x0 hardwired to zero, two combinational reads, one write.
module register_file_32x32
  import rv_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  register_file_32x32_if.slave  bus
);

  logic             we_ok;
  reg_onehot_t      load_en;
  logic             unused_x0_en;
  logic [WIDTH-1:0] regs [NUM_REGS-1:1];

  // Qualify the enable before decode so X on we/rd_addr cannot reach any register.
  always_comb begin
    we_ok = 1'b0;
    if (bus.we && (bus.rd_addr != REG_ZERO)) begin
      we_ok = 1'b1;
    end
  end

  demultiplexor1bit_1_32 u_we_demux (
    .in  (we_ok),
    .sel (bus.rd_addr),
    .out (load_en)
  );

  assign unused_x0_en = load_en[0];

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs[i] <= '0;
      end else if (load_en[i]) begin
        regs[i] <= bus.rd_data;
      end
    end
  end

  always_comb begin
    bus.rs1_data = '0;
    if (rst_n && (bus.rs1_addr != REG_ZERO)) begin
      if (BYPASS && we_ok && (bus.rs1_addr == bus.rd_addr)) begin
        bus.rs1_data = bus.rd_data;
      end else begin
        bus.rs1_data = regs[bus.rs1_addr];
      end
    end
  end

  always_comb begin
    bus.rs2_data = '0;
    if (rst_n && (bus.rs2_addr != REG_ZERO)) begin
      if (BYPASS && we_ok && (bus.rs2_addr == bus.rd_addr)) begin
        bus.rs2_data = bus.rd_data;
      end else begin
        bus.rs2_data = regs[bus.rs2_addr];
      end
    end
  end

endmodule
